// File: rtl/div8x4_seq_if.sv
// Handshake and operand/result bundle for the 8/4 sequential divider.
// The requester drives start and the operands; the divider returns the
// quotient, remainder, ready and overflow flags.
interface div8x4_seq_if;
  logic       start;
  logic [7:0] p;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] r;
  logic       ready;
  logic       ovf;

  modport master (
    output start, p, d,
    input  q, r, ready, ovf
  );

  modport slave (
    input  start, p, d,
    output q, r, ready, ovf
  );
endinterface

// File: rtl/div8x4_seq.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor giving a
// 4-bit quotient and remainder after four iteration cycles. Shares the
// start/ready handshake of the 4x4 shift-add multiplier so it can undo or
// check a product. Quotients that do not fit in 4 bits (including a zero
// divisor) are flagged on ovf immediately with all-ones results.
module div8x4_seq (
  input logic         clk,
  input logic         rst,
  div8x4_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, stateNext;
  logic [3:0] rem, remNext;
  logic [3:0] sh, shNext;
  logic [3:0] dv, dvNext;
  logic [1:0] cnt, cntNext;
  logic [3:0] q, qNext;
  logic [3:0] r, rNext;
  logic       ready, readyNext;
  logic       ovf, ovfNext;
  logic [4:0] t;
  logic       qbit;

  // Next-state and datapath: a start always wins over an iteration step.
  // T < 2*DV holds throughout, so T - DV fits in 4 bits and the low-nibble
  // subtraction gives the exact new partial remainder.
  always_comb begin
    stateNext = state;
    remNext   = rem;
    shNext    = sh;
    dvNext    = dv;
    cntNext   = cnt;
    qNext     = q;
    rNext     = r;
    readyNext = ready;
    ovfNext   = ovf;
    t         = {rem, sh[3]};
    qbit      = 1'b0;

    if (bus.start) begin
      if (bus.p[7:4] >= bus.d) begin
        stateNext = DONE;
        qNext     = 4'hF;
        rNext     = 4'hF;
        ovfNext   = 1'b1;
        readyNext = 1'b1;
      end else begin
        stateNext = CALC;
        remNext   = bus.p[7:4];
        shNext    = bus.p[3:0];
        dvNext    = bus.d;
        cntNext   = 2'd0;
        ovfNext   = 1'b0;
        readyNext = 1'b0;
      end
    end else if (state == CALC) begin
      if (t >= {1'b0, dv}) begin
        remNext = t[3:0] - dv;
        qbit    = 1'b1;
      end else begin
        remNext = t[3:0];
      end
      shNext  = {sh[2:0], qbit};
      cntNext = cnt + 2'd1;
      if (cnt == 2'd3) begin
        qNext     = shNext;
        rNext     = remNext;
        readyNext = 1'b1;
        stateNext = DONE;
      end
    end
  end

  // State and result registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= 4'd0;
      sh    <= 4'd0;
      dv    <= 4'd0;
      cnt   <= 2'd0;
      q     <= 4'd0;
      r     <= 4'd0;
      ready <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      state <= stateNext;
      rem   <= remNext;
      sh    <= shNext;
      dv    <= dvNext;
      cnt   <= cntNext;
      q     <= qNext;
      r     <= rNext;
      ready <= readyNext;
      ovf   <= ovfNext;
    end
  end

  assign bus.q     = q;
  assign bus.r     = r;
  assign bus.ready = ready;
  assign bus.ovf   = ovf;

endmodule

// File: tb/tb_div8x4_seq.sv
// Testbench for div8x4_seq: directed and random divisions. Stimulus pushes
// the expected {q, r, ovf} into a queue; an independent monitor pops and
// compares whenever the divider presents a result.
module tb_div8x4_seq;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  logic [8:0] expQueue[$];
  logic       startSeen;
  logic       rstSeen;
  logic       prevReady;

  div8x4_seq_if bus();

  div8x4_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // One start pulse sampled on a single edge; returns on the following negedge.
  task automatic driveStart(input logic [7:0] p, input logic [3:0] d);
    @(negedge clk);
    bus.start = 1'b1;
    bus.p     = p;
    bus.d     = d;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Issues one division, queues its expected result and checks latency.
  task automatic applyStimulus(input logic [7:0] p, input logic [3:0] d,
                               input logic [3:0] expQ, input logic [3:0] expR,
                               input logic expOvf);
    int n;
    expQueue.push_back({expQ, expR, expOvf});
    driveStart(p, d);
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, expOvf ? 0 : 4);
    @(negedge clk);
  endtask

  // Record what the divider saw on each rising edge.
  always @(posedge clk) begin
    startSeen = bus.start;
    rstSeen   = rst;
  end

  // Monitor: a result is presented when ready rises or a start was just taken
  // with ready high (overflow path).
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rstSeen && bus.ready === 1'b1 && (prevReady !== 1'b1 || startSeen === 1'b1)) begin
      if (expQueue.size() == 0) begin
        checkOutput("unexpected result", 1, 0);
      end else begin
        e = expQueue.pop_front();
        checkOutput("quotient", int'(bus.q), int'(e[8:5]));
        checkOutput("remainder", int'(bus.r), int'(e[4:1]));
        checkOutput("overflow", int'(bus.ovf), int'(e[0]));
      end
    end
    prevReady = bus.ready;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Directed, exhaustive-product and random stimulus.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.p       = 8'd0;
    bus.d       = 4'd0;
    prevReady   = 1'b0;
    startSeen   = 1'b0;
    rstSeen     = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset q", int'(bus.q), 0);
    checkOutput("reset r", int'(bus.r), 0);
    checkOutput("reset ready", int'(bus.ready), 1);
    checkOutput("reset ovf", int'(bus.ovf), 0);

    bus.start = 1'b1;
    bus.p     = 8'hF0;
    bus.d     = 4'd1;
    @(negedge clk);
    checkOutput("reset+start q", int'(bus.q), 0);
    checkOutput("reset+start ovf", int'(bus.ovf), 0);
    checkOutput("reset+start ready", int'(bus.ready), 1);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);

    applyStimulus(8'd143, 4'd13, 4'd11, 4'd0, 1'b0);
    applyStimulus(8'd200, 4'd15, 4'd13, 4'd5, 1'b0);
    applyStimulus(8'd0,   4'd7,  4'd0,  4'd0, 1'b0);
    applyStimulus(8'd225, 4'd15, 4'd15, 4'd0, 1'b0);
    applyStimulus(8'h9F,  4'd10, 4'd15, 4'd9, 1'b0);

    applyStimulus(8'hF0, 4'd15, 4'hF, 4'hF, 1'b1);
    applyStimulus(8'h37, 4'd0,  4'hF, 4'hF, 1'b1);
    applyStimulus(8'd100, 4'd9, 4'd11, 4'd1, 1'b0);

    // Restart: second start lands on edge 2 of the first division.
    driveStart(8'd143, 4'd13);
    applyStimulus(8'd100, 4'd9, 4'd11, 4'd1, 1'b0);

    // Reset mid-division drops to reset values with no result presented.
    driveStart(8'd200, 4'd15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset q", int'(bus.q), 0);
    checkOutput("midreset r", int'(bus.r), 0);
    checkOutput("midreset ready", int'(bus.ready), 1);
    repeat (6) @(negedge clk);

    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        applyStimulus(8'(a * b), 4'(b), 4'(a), 4'd0, 1'b0);
      end
    end

    for (int i = 0; i < 1000; i++) begin
      int dd;
      int pp;
      dd = int'($urandom_range(1, 15));
      pp = int'($urandom_range(0, dd * 16 - 1));
      applyStimulus(8'(pp), 4'(dd), 4'(pp / dd), 4'(pp % dd), 1'b0);
    end

    repeat (2) @(negedge clk);
    checkOutput("queue drained", expQueue.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/div8x4_seq.md
# div8x4_seq

Sequential restoring divider: the inverse of the 4x4 shift-add multiplier block. It divides an 8-bit dividend by a 4-bit divisor and returns a 4-bit quotient and 4-bit remainder after four iteration cycles. It uses the same START/READY handshake as the multiplier, so it sits beside it in the arithmetic datapath and can check or undo a product.

## Interface
- No parameters; widths are fixed (dividend 8, divisor/quotient/remainder 4).
- CK     input   1  clock; all state updates on the rising edge
- RST    input   1  reset, synchronous, active-high
- START  input   1  sampled each edge; 1 loads operands and (re)starts a division
- P      input   8  dividend
- D      input   4  divisor
- Q      output  4  quotient, registered
- R      output  4  remainder, registered
- READY  output  1  1 = idle or result valid; 0 = division in progress
- OVF    output  1  1 = last division overflowed (quotient not representable, or D = 0)

## Operation
- State machine with three states: IDLE, CALC, DONE. Registers:
  - REM: 4-bit partial remainder
  - SH: 4-bit shift register; holds the low dividend bits, quotient bits shift in from the LSB
  - DV: 4-bit latched divisor
  - CNT: 2-bit iteration counter
- Reset (RST = 1 at an edge, has priority over everything):
  - state goes to IDLE
  - Q = 0, R = 0, READY = 1, OVF = 0, CNT = 0
- START = 1 at an edge, in any state, with RST = 0:
  - Overflow check: if P[7:4] >= D (this includes D = 0), go to DONE, set Q = 4'hF, R = 4'hF, OVF = 1, READY = 1.
  - Otherwise load REM = P[7:4], SH = P[3:0], DV = D, CNT = 0, OVF = 0, READY = 0, and go to CALC.
  - START during CALC aborts the current division and restarts with the new operands.
- CALC step, once per edge while START = 0:
  - Form T = {REM, SH[3]} (5 bits).
  - If T >= DV: REM = T - DV and qbit = 1. Otherwise REM = T[3:0] and qbit = 0.
  - SH = {SH[2:0], qbit}, CNT = CNT + 1.
  - T < 2*DV always holds, so REM never exceeds 4 bits.
- On the step where CNT = 3:
  - Q = new SH value, R = new REM value, READY = 1, state goes to DONE.
  - CNT wraps to 0.
- In DONE and IDLE, Q, R and OVF hold until the next START or RST. START held high continuously reloads every edge, so READY stays 0 (non-overflow case).
- Q and R do not change during CALC; they keep the previous result until the fourth step completes.

## Timing
- Edge 0 samples START = 1; READY is 0 after edge 0.
- Edges 1–4 perform quotient bits 3 down to 0.
- After edge 4: READY = 1, and Q, R, OVF are valid.
- Latency is 4 cycles from the START sample edge to valid result.
- Overflow case: result and READY = 1 are visible after edge 0 (latency 0, READY never drops).
- Next START is accepted on any edge, including the same edge on which READY rises.
- RST asserted mid-division: after that edge all outputs take reset values; START on the same edge is ignored.
- All outputs come directly from registers, with no combinational path from any input.

## Test plan
- Reset: RST = 1 for one edge → Q = 0, R = 0, READY = 1, OVF = 0. Assert START with RST on the same edge → still the reset values.
- Basic divisions, each checked with READY = 0 for 4 cycles and then READY = 1 after edge 4:
  - P = 143, D = 13 → Q = 11, R = 0, OVF = 0.
  - P = 200, D = 15 → Q = 13, R = 5.
  - P = 0, D = 7 → Q = 0, R = 0.
- Boundaries:
  - P = 225, D = 15 → Q = 15, R = 0.
  - P = 0x9F, D = 10 (P[7:4] = 9 < 10) → Q = 15, R = 9.
- Overflow:
  - P = 0xF0, D = 15 → OVF = 1, Q = 4'hF, R = 4'hF, READY = 1 after edge 0.
  - D = 0 with any P → same response.
  - A following valid START clears OVF.
- Restart: START with P = 143, D = 13; at edge 2 pulse START with P = 100, D = 9 → after edge 6, Q = 11, R = 1. No intermediate READY pulse occurs.
- Random check against the multiplier: for all A, B in 1..15, feed P = A*B, D = B → Q = A, R = 0. Also check Q*D + R = P, with R < D, for 1000 random legal (P, D) pairs.
